// File: rtl/id_stage_sb.sv
// id_stage_sb
//   Instruction-decode stage that sits between IF and EX. It holds one
//   instruction, decodes its register fields and immediate (RV32I formats),
//   and issues it to EX only when no source register has an outstanding
//   write. Each register has a small counter that records how many issued
//   instructions will still write it. When BYPASS is set, a source whose last
//   pending write retires this cycle takes the write-back data directly.
//
// Ports
//   clk, resetn_i           clock, asynchronous active-low reset
//   registers_i             register file contents, one XLEN word per register
//   valid_i/instr_i/pc_i    instruction offered by IF
//   notify_o                IF instruction taken this cycle
//   valid_o/notify_i        issue request to EX / EX accepts it
//   instr_o/pc_o/rd_o       held instruction, PC and destination index
//   rs1d_o/rs2d_o/imm_o     source operands and sign-extended immediate
//   wb_valid_i/wb_rd_i      write-back of a register this cycle
//   wb_data_i               write-back data (bypass source)
//   flush_i                 drop the held instruction
//   stall_o                 holding an instruction blocked by a hazard
//   sb_err_o                sticky: write-back seen for a register with no pending write
module id_stage_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int CNT_W  = 1,
  parameter int BYPASS = 0,
  localparam int RIDX_W = $clog2(NREGS)
) (
  input  logic                       clk,
  input  logic                       resetn_i,
  input  logic [NREGS-1:0][XLEN-1:0] registers_i,
  input  logic                       valid_i,
  input  logic [31:0]                instr_i,
  input  logic [XLEN-1:0]            pc_i,
  output logic                       notify_o,
  output logic                       valid_o,
  input  logic                       notify_i,
  output logic [31:0]                instr_o,
  output logic [XLEN-1:0]            pc_o,
  output logic [RIDX_W-1:0]          rd_o,
  output logic [XLEN-1:0]            rs1d_o,
  output logic [XLEN-1:0]            rs2d_o,
  output logic [XLEN-1:0]            imm_o,
  input  logic                       wb_valid_i,
  input  logic [RIDX_W-1:0]          wb_rd_i,
  input  logic [XLEN-1:0]            wb_data_i,
  input  logic                       flush_i,
  output logic                       stall_o,
  output logic                       sb_err_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Immediate decode; every opcode not listed explicitly uses the I format.
  function automatic logic signed [31:0] imm_decode(input logic [31:0] ins);
    logic signed [31:0] imm;
    case (ins[6:0])
      OPC_OP:             imm = '0;
      OPC_STORE:          imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OPC_BRANCH:         imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm = {ins[31:12], 12'b0};
      OPC_JAL:            imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:            imm = {{20{ins[31]}}, ins[31:20]};
    endcase
    return imm;
  endfunction

  logic                full_p0;
  logic [31:0]         instr_p0;
  logic [XLEN-1:0]     pc_p0;
  logic [CNT_W-1:0]    cnt [NREGS];
  logic                sb_err_q;

  logic [6:0]          opcode;
  logic [RIDX_W-1:0]   rd, rs1, rs2;
  logic                writes_rd, uses_rs1, uses_rs2;
  logic                byp1, byp2, hz1, hz2, full_blk, hazard;
  logic                issue, accept;
  logic [NREGS-1:0]    inc_vec, dec_vec;
  logic signed [31:0]  imm32;

  always_comb begin
    opcode    = instr_p0[6:0];
    rd        = instr_p0[7 +: RIDX_W];
    rs1       = instr_p0[15 +: RIDX_W];
    rs2       = instr_p0[20 +: RIDX_W];
    writes_rd = (opcode != OPC_BRANCH) && (opcode != OPC_STORE) && (rd != '0);
    uses_rs1  = (opcode != OPC_LUI) && (opcode != OPC_AUIPC) && (opcode != OPC_JAL);
    uses_rs2  = (opcode == OPC_BRANCH) || (opcode == OPC_STORE) || (opcode == OPC_OP);

    // A source may forward only when exactly one write is pending and it retires now.
    byp1 = (BYPASS != 0) && (rs1 != '0) && (cnt[rs1] == CNT_ONE) && wb_valid_i && (wb_rd_i == rs1);
    byp2 = (BYPASS != 0) && (rs2 != '0) && (cnt[rs2] == CNT_ONE) && wb_valid_i && (wb_rd_i == rs2);
    hz1  = uses_rs1 && (rs1 != '0) && (cnt[rs1] != '0) && !byp1;
    hz2  = uses_rs2 && (rs2 != '0) && (cnt[rs2] != '0) && !byp2;

    // A saturated destination counter cannot take another pending write.
    full_blk = writes_rd && (cnt[rd] == CNT_MAX);
    hazard   = hz1 || hz2 || full_blk;

    valid_o  = full_p0 && !hazard && !flush_i;
    stall_o  = full_p0 && hazard;
    issue    = valid_o && notify_i;
    accept   = valid_i && (!full_p0 || issue || flush_i);
    notify_o = accept;

    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < NREGS; r++) begin
      inc_vec[r] = issue && writes_rd && (rd == RIDX_W'(r));
      dec_vec[r] = wb_valid_i && (wb_rd_i == RIDX_W'(r));
    end

    imm32 = imm_decode(instr_p0);
  end

  assign instr_o  = instr_p0;
  assign pc_o     = pc_p0;
  assign rd_o     = rd;
  assign rs1d_o   = byp1 ? wb_data_i : registers_i[rs1];
  assign rs2d_o   = byp2 ? wb_data_i : registers_i[rs2];
  assign imm_o    = XLEN'(imm32);
  assign sb_err_o = sb_err_q;

  // IF -> ID boundary: holding register
  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      full_p0  <= 1'b0;
      instr_p0 <= '0;
      pc_p0    <= '0;
    end else if (accept) begin
      full_p0  <= 1'b1;
      instr_p0 <= instr_i;
      pc_p0    <= pc_i;
    end else if (issue || flush_i) begin
      full_p0  <= 1'b0;
    end
  end

  // ID -> EX boundary: scoreboard counters track writes issued but not yet written back
  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      sb_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          cnt[r] <= cnt[r] + CNT_ONE;
        end else if (dec_vec[r] && !inc_vec[r]) begin
          if (cnt[r] == '0) sb_err_q <= 1'b1;
          else              cnt[r]   <= cnt[r] - CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_id_stage_sb.sv
// tb_id_stage_sb
//   Two instances of id_stage_sb share one stimulus stream: instance a is the
//   legacy configuration (CNT_W=1, BYPASS=0), instance b uses CNT_W=2 with
//   bypass. A behavioural model per instance predicts every output each cycle.
module tb_id_stage_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       resetn_i;
  logic [NREGS-1:0][XLEN-1:0] registers_i;
  logic                       valid_i;
  logic [31:0]                instr_i;
  logic [XLEN-1:0]            pc_i;
  logic                       notify_i;
  logic                       wb_valid_i;
  logic [4:0]                 wb_rd_i;
  logic [XLEN-1:0]            wb_data_i;
  logic                       flush_i;

  logic            notify_w [2];
  logic            valid_w  [2];
  logic            stall_w  [2];
  logic            err_w    [2];
  logic [31:0]     instr_w  [2];
  logic [XLEN-1:0] pc_w     [2];
  logic [4:0]      rd_w     [2];
  logic [XLEN-1:0] rs1d_w   [2];
  logic [XLEN-1:0] rs2d_w   [2];
  logic [XLEN-1:0] imm_w    [2];

  id_stage_sb #(.XLEN(XLEN), .NREGS(NREGS), .CNT_W(1), .BYPASS(0)) dut_a (
    .clk(clk), .resetn_i(resetn_i), .registers_i(registers_i),
    .valid_i(valid_i), .instr_i(instr_i), .pc_i(pc_i), .notify_o(notify_w[0]),
    .valid_o(valid_w[0]), .notify_i(notify_i), .instr_o(instr_w[0]), .pc_o(pc_w[0]),
    .rd_o(rd_w[0]), .rs1d_o(rs1d_w[0]), .rs2d_o(rs2d_w[0]), .imm_o(imm_w[0]),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .flush_i(flush_i), .stall_o(stall_w[0]), .sb_err_o(err_w[0]));

  id_stage_sb #(.XLEN(XLEN), .NREGS(NREGS), .CNT_W(2), .BYPASS(1)) dut_b (
    .clk(clk), .resetn_i(resetn_i), .registers_i(registers_i),
    .valid_i(valid_i), .instr_i(instr_i), .pc_i(pc_i), .notify_o(notify_w[1]),
    .valid_o(valid_w[1]), .notify_i(notify_i), .instr_o(instr_w[1]), .pc_o(pc_w[1]),
    .rd_o(rd_w[1]), .rs1d_o(rs1d_w[1]), .rs2d_o(rs2d_w[1]), .imm_o(imm_w[1]),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .flush_i(flush_i), .stall_o(stall_w[1]), .sb_err_o(err_w[1]));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state, one slot per instance
  bit          m_full [2];
  logic [31:0] m_ins  [2];
  logic [31:0] m_pc   [2];
  int          m_cnt  [2][NREGS];
  bit          m_err  [2];

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_LUI = 7'b0110111,
                         OP_AUI = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  function automatic logic [31:0] ref_imm(input logic [31:0] x);
    logic [31:0] s;
    s = x[31] ? 32'hffff_ffff : 32'h0;
    case (x[6:0])
      OP_R:          return 32'h0;
      OP_ST:         return (s << 11) | (32'(x[30:25]) << 5) | 32'(x[11:7]);
      OP_BR:         return (s << 12) | (32'(x[7]) << 11) | (32'(x[30:25]) << 5) | (32'(x[11:8]) << 1);
      OP_LUI, OP_AUI: return x & 32'hffff_f000;
      OP_JAL:        return (s << 20) | (32'(x[19:12]) << 12) | (32'(x[20]) << 11) | (32'(x[30:21]) << 1);
      default:       return (s << 11) | 32'(x[30:20]);
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_full[k] = 0;
      m_err[k]  = 0;
      for (int r = 0; r < NREGS; r++) m_cnt[k][r] = 0;
    end
  endtask

  // Compare instance k against the model for the current inputs, then advance the model.
  task automatic model_step(input int k);
    string p;
    int cw, maxc, rd, r1, r2;
    logic [6:0] op;
    bit wr, u1, u2, by1, by2, bl1, bl2, haz, ev, es, iss, acc, inc, dec;
    p    = (k == 0) ? "a." : "b.";
    cw   = (k == 0) ? 1 : 2;
    maxc = (1 << cw) - 1;
    op   = m_ins[k][6:0];
    rd   = int'(m_ins[k][11:7]);
    r1   = int'(m_ins[k][19:15]);
    r2   = int'(m_ins[k][24:20]);
    wr   = (op != OP_BR) && (op != OP_ST) && (rd != 0);
    u1   = !(op == OP_LUI || op == OP_AUI || op == OP_JAL);
    u2   = (op == OP_BR) || (op == OP_ST) || (op == OP_R);
    by1  = (k == 1) && r1 != 0 && m_cnt[k][r1] == 1 && wb_valid_i && int'(wb_rd_i) == r1;
    by2  = (k == 1) && r2 != 0 && m_cnt[k][r2] == 1 && wb_valid_i && int'(wb_rd_i) == r2;
    bl1  = u1 && r1 != 0 && m_cnt[k][r1] != 0 && !by1;
    bl2  = u2 && r2 != 0 && m_cnt[k][r2] != 0 && !by2;
    haz  = bl1 || bl2 || (wr && m_cnt[k][rd] == maxc);
    ev   = m_full[k] && !haz && !flush_i;
    es   = m_full[k] && haz;
    iss  = ev && notify_i;
    acc  = valid_i && (!m_full[k] || iss || flush_i);

    chk({p, "notify"}, 64'(notify_w[k]), 64'(acc));
    chk({p, "valid"},  64'(valid_w[k]),  64'(ev));
    chk({p, "stall"},  64'(stall_w[k]),  64'(es));
    chk({p, "sb_err"}, 64'(err_w[k]),    64'(m_err[k]));
    if (m_full[k]) begin
      chk({p, "instr"}, 64'(instr_w[k]), 64'(m_ins[k]));
      chk({p, "pc"},    64'(pc_w[k]),    64'(m_pc[k]));
      chk({p, "rd"},    64'(rd_w[k]),    64'(rd));
      chk({p, "imm"},   64'(imm_w[k]),   64'(ref_imm(m_ins[k])));
      if (u1) chk({p, "rs1d"}, 64'(rs1d_w[k]), 64'(by1 ? wb_data_i : registers_i[r1]));
      if (u2) chk({p, "rs2d"}, 64'(rs2d_w[k]), 64'(by2 ? wb_data_i : registers_i[r2]));
    end

    for (int r = 1; r < NREGS; r++) begin
      inc = iss && wr && rd == r;
      dec = wb_valid_i && int'(wb_rd_i) == r;
      if (inc && !dec) m_cnt[k][r]++;
      else if (dec && !inc) begin
        if (m_cnt[k][r] == 0) m_err[k] = 1;
        else m_cnt[k][r]--;
      end
    end
    if (acc) begin
      m_full[k] = 1;
      m_ins[k]  = instr_i;
      m_pc[k]   = pc_i;
    end else if (iss || flush_i) begin
      m_full[k] = 0;
    end
  endtask

  task automatic step(input logic vin, input logic [31:0] ins, input logic nt,
                      input logic wv, input logic [4:0] wr, input logic fl);
    @(posedge clk);
    #1;
    valid_i    = vin;
    instr_i    = ins;
    pc_i       = $urandom;
    notify_i   = nt;
    wb_valid_i = wv;
    wb_rd_i    = wr;
    wb_data_i  = $urandom;
    flush_i    = fl;
    for (int r = 0; r < NREGS; r++) registers_i[r] = $urandom;
    @(negedge clk);
    model_step(0);
    model_step(1);
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #2;
    valid_i    = 1'b0;
    notify_i   = 1'b0;
    wb_valid_i = 1'b0;
    flush_i    = 1'b0;
    resetn_i   = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst.valid",  64'(valid_w[k]),  64'(0));
      chk("rst.stall",  64'(stall_w[k]),  64'(0));
      chk("rst.sb_err", 64'(err_w[k]),    64'(0));
      chk("rst.notify", 64'(notify_w[k]), 64'(0));
    end
    model_reset();
    @(negedge clk);
    resetn_i = 1'b1;
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, OP_R};
  endfunction
  function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, OP_I};
  endfunction
  function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_ST};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9];
    logic [31:0] x;
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_AUI, OP_JAL, OP_JALR};
    x = $urandom;
    x[6:0]   = ops[$urandom_range(0, 8)];
    x[11:7]  = 5'($urandom_range(0, 7));
    x[19:15] = 5'($urandom_range(0, 7));
    x[24:20] = 5'($urandom_range(0, 7));
    return x;
  endfunction

  initial begin
    logic       vin, nt, wv, fl;
    logic [4:0] wr;
    int         r, p_under;

    resetn_i = 1'b1; valid_i = 0; instr_i = '0; pc_i = '0; notify_i = 0;
    wb_valid_i = 0; wb_rd_i = '0; wb_data_i = '0; flush_i = 0; registers_i = '0;
    async_reset();

    // Independent ADDs: first valid_o one cycle after first notify_o, then one per cycle.
    step(1, enc_r(5'd1, 5'd2, 5'd3), 1, 0, 5'd0, 0);
    chk("lat.notify", 64'(notify_w[0]), 64'(1));
    chk("lat.valid0", 64'(valid_w[0]),  64'(0));
    step(1, enc_r(5'd4, 5'd2, 5'd3), 1, 0, 5'd0, 0);
    chk("lat.valid1", 64'(valid_w[0]),  64'(1));
    step(1, enc_r(5'd5, 5'd2, 5'd3), 1, 0, 5'd0, 0);
    chk("b2b.valid",  64'(valid_w[0]),  64'(1));
    chk("b2b.notify", 64'(notify_w[0]), 64'(1));
    async_reset();

    // ADDI x5 then ADD x6,x5,x5: a stalls until after wb, b forwards in the wb cycle.
    step(1, enc_i(5'd5, 5'd0, 12'd1), 1, 0, 5'd0, 0);
    step(1, enc_r(5'd6, 5'd5, 5'd5), 1, 0, 5'd0, 0);
    step(0, 32'h0, 1, 0, 5'd0, 0);
    chk("raw.a.stall", 64'(stall_w[0]), 64'(1));
    chk("raw.b.stall", 64'(stall_w[1]), 64'(1));
    step(0, 32'h0, 1, 1, 5'd5, 0);
    chk("raw.a.stallwb", 64'(stall_w[0]), 64'(1));
    chk("byp.b.valid",   64'(valid_w[1]), 64'(1));
    chk("byp.b.rs1d",    64'(rs1d_w[1]),  64'(wb_data_i));
    chk("byp.b.rs2d",    64'(rs2d_w[1]),  64'(wb_data_i));
    step(0, 32'h0, 1, 0, 5'd0, 0);
    chk("raw.a.valid",   64'(valid_w[0]), 64'(1));
    async_reset();

    // Flush of a stalled instruction, then reset mid-stall clears the counters.
    step(1, enc_i(5'd5, 5'd0, 12'd1), 1, 0, 5'd0, 0);
    step(1, enc_r(5'd6, 5'd5, 5'd5), 1, 0, 5'd0, 0);
    step(0, 32'h0, 1, 0, 5'd0, 1);
    chk("flush.valid", 64'(valid_w[0]), 64'(0));
    step(0, 32'h0, 1, 0, 5'd0, 0);
    chk("flush.empty", 64'(stall_w[0] | valid_w[0]), 64'(0));
    step(1, enc_r(5'd6, 5'd5, 5'd5), 0, 0, 5'd0, 0);
    step(0, 32'h0, 0, 0, 5'd0, 0);
    chk("pre.rst.stall", 64'(stall_w[0]), 64'(1));
    async_reset();
    step(1, enc_r(5'd6, 5'd5, 5'd5), 1, 0, 5'd0, 0);
    step(0, 32'h0, 1, 0, 5'd0, 0);
    chk("rst.cnt.a", 64'(valid_w[0]), 64'(1));
    chk("rst.cnt.b", 64'(valid_w[1]), 64'(1));
    async_reset();

    // Four ADDI x7 with no wb: b (CNT_W=2) issues three, the fourth stalls until after wb x7.
    for (int i = 0; i < 4; i++) step(1, enc_i(5'd7, 5'd0, 12'd3), 1, 0, 5'd0, 0);
    step(0, 32'h0, 1, 0, 5'd0, 0);
    chk("sat.b.stall",   64'(stall_w[1]), 64'(1));
    step(0, 32'h0, 1, 1, 5'd7, 0);
    chk("sat.b.stallwb", 64'(stall_w[1]), 64'(1));
    step(0, 32'h0, 1, 0, 5'd0, 0);
    chk("sat.b.valid",   64'(valid_w[1]), 64'(1));
    async_reset();

    // x0 is never tracked.
    for (int i = 0; i < 4; i++) begin
      step(1, enc_i(5'd0, 5'd0, 12'd5), 1, 0, 5'd0, 0);
      chk("x0.a.stall", 64'(stall_w[0]), 64'(0));
      chk("x0.b.stall", 64'(stall_w[1]), 64'(0));
    end
    step(1, enc_sw(5'd0, 5'd0, 12'd8), 1, 0, 5'd0, 0);
    step(0, 32'h0, 1, 0, 5'd0, 0);
    chk("sw0.a.valid", 64'(valid_w[0]), 64'(1));
    async_reset();

    // Simultaneous issue and wb of x3 keeps the count; then an underflow on x9.
    step(1, enc_i(5'd3, 5'd0, 12'd1), 1, 0, 5'd0, 0);
    step(1, enc_i(5'd3, 5'd0, 12'd2), 1, 0, 5'd0, 0);
    step(0, 32'h0, 1, 1, 5'd3, 0);
    chk("same.b.valid", 64'(valid_w[1]), 64'(1));
    step(1, enc_r(5'd8, 5'd3, 5'd3), 1, 0, 5'd0, 0);
    step(0, 32'h0, 1, 0, 5'd0, 0);
    chk("same.b.stall", 64'(stall_w[1]), 64'(1));
    step(0, 32'h0, 1, 1, 5'd9, 0);
    step(0, 32'h0, 1, 0, 5'd0, 0);
    chk("uf.a.err", 64'(err_w[0]), 64'(1));
    chk("uf.b.err", 64'(err_w[1]), 64'(1));
    step(0, 32'h0, 1, 0, 5'd0, 0);
    chk("uf.sticky", 64'(err_w[1]), 64'(1));

    // Randomized traffic, with underflows permitted only in the last segment.
    for (int seg = 0; seg < 3; seg++) begin
      async_reset();
      p_under = (seg == 2) ? 3 : 0;
      for (int i = 0; i < 600; i++) begin
        vin = ($urandom_range(0, 3) != 0);
        nt  = ($urandom_range(0, 3) != 0);
        fl  = ($urandom_range(0, 19) == 0);
        wv  = 0;
        r   = $urandom_range(1, 7);
        wr  = 5'(r);
        if ((m_cnt[0][r] > 0 && m_cnt[1][r] > 0) && $urandom_range(0, 1) == 1) wv = 1;
        else if ($urandom_range(0, 99) < p_under) begin
          wv = 1;
          wr = 5'($urandom_range(0, 9));
        end
        step(vin, rand_instr(), nt, wv, wr, fl);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
